// File: rtl/i2s_master_tx.sv
// i2s_master_tx: I2S master transmitter for the DAC path.
// Derives BCK/LRCLK from sample_clk with a free-running divider, serialises one
// left/right pair per 64-BCK frame (standard I2S, one BCK of data delay, left while
// LRCLK is low) and takes samples through a single-entry valid/ready buffer.
// Optional feature: define I2S_TX_UNDERRUN_REPEAT_EN to resend the last transmitted
// pair on underrun instead of a zero frame.
module i2s_master_tx #(
  parameter int unsigned WIDTH        = 24,
  parameter int unsigned BCK_DIV_LOG2 = 3
) (
  input  logic             sample_clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       rate_sel,
  input  logic [WIDTH-1:0] sample_l,
  input  logic [WIDTH-1:0] sample_r,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             bck_o,
  output logic             lrclk_o,
  output logic             sdata_o,
  output logic             underrun
);

  // Divider is one bit wider than the longest frame count so the wrap value
  // 2^(p+7) is representable and detected as the next frame start.
  localparam int unsigned DW = BCK_DIV_LOG2 + 8;
  localparam int unsigned PW = $clog2(DW + 1);

  // Sample left-justified in a 32-bit slot, zero-padded below its LSB.
  function automatic logic [31:0] pad_slot(input logic [WIDTH-1:0] x);
    return 32'(x) << (32 - WIDTH);
  endfunction

  logic [DW-1:0]    r_div;
  logic [DW-1:0]    w_div_d;
  logic [1:0]       r_rate;
  logic [PW-1:0]    w_p;
  logic [DW-1:0]    w_tick_mask;
  logic [DW-1:0]    w_frame_mask;
  logic             w_bck;
  logic             w_lrclk;
  logic             w_tick;
  logic             w_frame_start;

  logic             r_full;
  logic [WIDTH-1:0] r_buf_l;
  logic [WIDTH-1:0] r_buf_r;

  logic [63:0]      r_sr;
  logic [63:0]      w_sr_d;
  logic [63:0]      w_load;

  logic             r_bck;
  logic             r_lrclk;
  logic             r_sdata;
  logic             r_underrun;
  logic             w_bck_d;
  logic             w_lrclk_d;
  logic             w_sdata_d;
  logic             w_underrun_d;

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  logic [WIDTH-1:0] r_last_l;
  logic [WIDTH-1:0] r_last_r;
`endif

  // p selects the divider bit that is BCK for the active rate.
  assign w_p = PW'(BCK_DIV_LOG2) - PW'(r_rate);

  // Decode BCK, LRCLK, falling-edge tick and frame start from the divider.
  always_comb begin
    w_tick_mask   = (DW'(2) << w_p) - DW'(1);
    w_frame_mask  = (DW'(2) << (w_p + PW'(6))) - DW'(1);
    w_bck         = |(r_div & (DW'(1) << w_p));
    w_lrclk       = |(r_div & (DW'(1) << (w_p + PW'(6))));
    w_tick        = en && ((r_div & w_tick_mask) == '0);
    w_frame_start = en && ((r_div & w_frame_mask) == '0);
  end

  // Divider next state: held at 0 while disabled; restarted at frame start so a
  // rate change never leaves stale high bits that would misalign the next frame.
  always_comb begin
    w_div_d = r_div + DW'(1);
    if (!en) begin
      w_div_d = '0;
    end else if (w_frame_start) begin
      w_div_d = DW'(1);
    end
  end

  // Divider and latched rate registers.
  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      r_div  <= '0;
      r_rate <= 2'd1;
    end else begin
      r_div <= w_div_d;
      if (w_frame_start) begin
        r_rate <= rate_sel;
      end
    end
  end

  // Holding buffer: accept only when empty, so accept and consume never coincide.
  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      r_full  <= 1'b0;
      r_buf_l <= '0;
      r_buf_r <= '0;
    end else if (sample_valid && !r_full) begin
      r_full  <= 1'b1;
      r_buf_l <= sample_l;
      r_buf_r <= sample_r;
    end else if (w_frame_start && r_full) begin
      r_full <= 1'b0;
    end
  end

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  // Remember the last pair actually sent so an underrun can repeat it.
  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      r_last_l <= '0;
      r_last_r <= '0;
    end else if (w_frame_start && r_full) begin
      r_last_l <= r_buf_l;
      r_last_r <= r_buf_r;
    end
  end

  // Frame content at frame start: buffered pair, else repeat of the last pair.
  always_comb begin
    w_load = {pad_slot(r_last_l), pad_slot(r_last_r)};
    if (r_full) begin
      w_load = {pad_slot(r_buf_l), pad_slot(r_buf_r)};
    end
  end
`else
  // Frame content at frame start: buffered pair, else silence.
  always_comb begin
    w_load = '0;
    if (r_full) begin
      w_load = {pad_slot(r_buf_l), pad_slot(r_buf_r)};
    end
  end
`endif

  // Serialiser: on each BCK falling edge emit the MSB, then shift; at frame start
  // the old last bit goes out in slot 0 while the new frame is loaded.
  always_comb begin
    w_sr_d    = r_sr;
    w_sdata_d = r_sdata;
    if (!en) begin
      w_sr_d    = '0;
      w_sdata_d = 1'b0;
    end else if (w_tick) begin
      w_sdata_d = r_sr[63];
      w_sr_d    = w_frame_start ? w_load : {r_sr[62:0], 1'b0};
    end
  end

  // Clock and status outputs, forced low while disabled.
  always_comb begin
    w_bck_d      = en && w_bck;
    w_lrclk_d    = en && w_lrclk;
    w_underrun_d = w_frame_start && !r_full;
  end

  // Output and shift registers: every output is one clock behind its divider value.
  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      r_sr       <= '0;
      r_bck      <= 1'b0;
      r_lrclk    <= 1'b0;
      r_sdata    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_sr       <= w_sr_d;
      r_bck      <= w_bck_d;
      r_lrclk    <= w_lrclk_d;
      r_sdata    <= w_sdata_d;
      r_underrun <= w_underrun_d;
    end
  end

  assign sample_ready = !r_full;
  assign bck_o        = r_bck;
  assign lrclk_o      = r_lrclk;
  assign sdata_o      = r_sdata;
  assign underrun     = r_underrun;

endmodule
